// File: rtl/fir_sat_div_signed.sv
// fir_sat_div_signed
// Sequential saturating signed 16-bit divider for the FIR datapath.
// Operands arrive over a valid/ready handshake. The quotient is produced by a
// 16-iteration radix-2 restoring division on operand magnitudes, then it is
// sign-corrected and presented over a second valid/ready handshake.
// Divide-by-zero and the single overflow case (-32768 / -1) bypass the
// iteration and return a saturated quotient.
// Optional feature macro: FIR_SATDIV_REM_EN adds the result_rem port, its
// output register and the remainder sign correction.

module fir_sat_div_signed (
    input  logic               system1000,
    input  logic               system1000_rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] result,
    output logic               div_zero
`ifdef FIR_SATDIV_REM_EN
    ,
    output logic signed [15:0] result_rem
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operand and iteration registers.
    // Magnitudes are held as unsigned 16-bit values: |-32768| = 32768 fits.
    logic [15:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic [15:0] part_rem;
    logic [15:0] quo;
    logic [3:0]  bit_cnt;
    logic        q_sign;
    logic        r_sign;
    logic        zero_case;
    logic        ovf_case;
`ifdef FIR_SATDIV_REM_EN
    logic signed [15:0] a_hold;
`endif

    logic        accept;
    logic        b_is_zero;
    logic        is_ovf;
    logic [15:0] a_mag;
    logic [15:0] b_mag;
    logic [16:0] shifted;
    logic [17:0] trial;
    logic        trial_ok;
    logic        unused_trial_msb;
    logic [15:0] q_signed;
    logic [15:0] sat_value;
`ifdef FIR_SATDIV_REM_EN
    logic [15:0] rem_signed;
`endif

    // The divider is ready exactly when it is idle; no path from in_valid.
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    assign b_is_zero = (b == 16'sd0);
    assign is_ovf    = (a == 16'sh8000) && (b == 16'shFFFF);

    assign a_mag = a[15] ? (16'd0 - $unsigned(a)) : $unsigned(a);
    assign b_mag = b[15] ? (16'd0 - $unsigned(b)) : $unsigned(b);

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // The partial remainder stays below the divisor (<= 32768), so a
    // successful trial result always fits in 16 bits and bit 16 stays zero.
    assign shifted          = {part_rem, dvd_mag[bit_cnt]};
    assign trial            = {1'b0, shifted} - {2'b00, dvs_mag};
    assign trial_ok         = ~trial[17];
    assign unused_trial_msb = trial[16];

    // Sign correction of the finished quotient; truncation toward zero
    // falls out of dividing magnitudes.
    assign q_signed  = q_sign ? (16'd0 - quo) : quo;
    assign sat_value = r_sign ? 16'h8000 : 16'h7FFF;
`ifdef FIR_SATDIV_REM_EN
    assign rem_signed = r_sign ? (16'd0 - part_rem) : part_rem;
`endif

    // State register.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: special operands skip CALC, CALC ends after bit 0.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (b_is_zero || is_ovf) begin
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (bit_cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept and one quotient bit per CALC cycle.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            dvd_mag   <= 16'd0;
            dvs_mag   <= 16'd0;
            part_rem  <= 16'd0;
            quo       <= 16'd0;
            bit_cnt   <= 4'd0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            zero_case <= 1'b0;
            ovf_case  <= 1'b0;
`ifdef FIR_SATDIV_REM_EN
            a_hold    <= 16'sd0;
`endif
        end else if (accept) begin
            dvd_mag   <= a_mag;
            dvs_mag   <= b_mag;
            part_rem  <= 16'd0;
            quo       <= 16'd0;
            bit_cnt   <= 4'd15;
            q_sign    <= a[15] ^ b[15];
            r_sign    <= a[15];
            zero_case <= b_is_zero;
            ovf_case  <= is_ovf;
`ifdef FIR_SATDIV_REM_EN
            a_hold    <= a;
`endif
        end else if (state == CALC) begin
            part_rem <= trial_ok ? trial[15:0] : shifted[15:0];
            quo      <= {quo[14:0], trial_ok};
            bit_cnt  <= bit_cnt - 4'd1;
        end
    end

    // Output registers: loaded once on the first DONE cycle, then held
    // until the consumer takes the result.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            out_valid  <= 1'b0;
            result     <= 16'sd0;
            div_zero   <= 1'b0;
`ifdef FIR_SATDIV_REM_EN
            result_rem <= 16'sd0;
`endif
        end else if (state == DONE) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                if (zero_case) begin
                    result     <= sat_value;
                    div_zero   <= 1'b1;
`ifdef FIR_SATDIV_REM_EN
                    result_rem <= a_hold;
`endif
                end else if (ovf_case) begin
                    result     <= 16'sh7FFF;
                    div_zero   <= 1'b0;
`ifdef FIR_SATDIV_REM_EN
                    result_rem <= 16'sd0;
`endif
                end else begin
                    result     <= q_signed;
                    div_zero   <= 1'b0;
`ifdef FIR_SATDIV_REM_EN
                    result_rem <= rem_signed;
`endif
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
